// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform command path: command words, header size,
// AXIS routing constants and the packetizer state encoding.
// Latency: n/a (package). Backpressure: n/a.
package waveform_pkg;

  // Command words as seen on the wire (ASCII, MSB first).
  localparam logic [31:0] CMD_WWDA = 32'h5757_4441;  // "WWDA" waveform data
  localparam logic [31:0] CMD_WWCC = 32'h5757_4343;  // "WWCC"
  localparam logic [31:0] CMD_WWFF = 32'h5757_4646;  // "WWFF"
  localparam logic [31:0] CMD_RRCC = 32'h5252_4343;  // "RRCC"
  localparam logic [31:0] CMD_RRFF = 32'h5252_4646;  // "RRFF"

  // CMD, ID, IND, LEN
  localparam int unsigned HDR_WORDS = 4;

  localparam logic [3:0] TDEST_WFRM = 4'b0010;
  localparam logic [3:0] TID_WFRM   = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ID,
    ST_IND,
    ST_LEN,
    ST_DATA,
    ST_TRL,   // checksum trailer, only reachable when the checksum is built in
    ST_GAP
  } wfrm_state_e;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wfrm_axis_out_reg.sv
// Single-entry registered AXIS output stage (data + last, valid/ready).
// Latency: 1 cycle from load to vld_o. Backpressure: accepts a load only when
// empty or draining (can_ld_o = !vld_o | rdy_i); holds dat_o/last_o while stalled.
// Ports: clk_i/rst_i (sync, active-high); ld_vld_i/ld_dat_i/ld_last_i load side;
// rdy_i downstream ready; vld_o/dat_o/last_o registered outputs; can_ld_o load slot.
module wfrm_axis_out_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_vld_i,
  input  logic [31:0] ld_dat_i,
  input  logic        ld_last_i,
  input  logic        rdy_i,
  output logic        vld_o,
  output logic [31:0] dat_o,
  output logic        last_o,
  output logic        can_ld_o
);

  logic        vld_q;
  logic [31:0] dat_q;
  logic        last_q;

  assign can_ld_o = !vld_q || rdy_i;
  assign vld_o    = vld_q;
  assign dat_o    = dat_q;
  assign last_o   = last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
    end else if (can_ld_o) begin
      vld_q  <= ld_vld_i;
      last_q <= ld_vld_i && ld_last_i;
      if (ld_vld_i) begin
        dat_q <= ld_dat_i;
      end
    end
  end

endmodule

// File: rtl/waveform_packetizer.sv
// Frames a raw 32-bit sample stream into WWDA command packets (CMD, ID, IND, LEN, payload).
// Latency: first header word valid 2 cycles after an accepted start; payload 1 cycle after source handshake.
// Backpressure: single registered output stage; s_axis_tready follows output slot availability in DATA only.
// Ports: axi_tclk/axi_treset (sync, active-high); start/wfrm_id/wfrm_len request; busy/done status;
// s_axis_* sample input; tdata/tvalid/tlast/tkeep/tdest/tid/tuser/tready packet output.
// Build option: define WFRM_PKT_CHECKSUM_EN to append an XOR-of-payload trailer word to every packet.
module waveform_packetizer
  import waveform_pkg::*;
#(
  parameter int unsigned CHUNK_WORDS = 256,
  parameter int unsigned GAP_CYCLES  = 24,
  parameter logic [31:0] CMD_WORD    = CMD_WWDA
) (
  input  logic        axi_tclk,
  input  logic        axi_treset,
  input  logic        start,
  input  logic [31:0] wfrm_id,
  input  logic [31:0] wfrm_len,
  output logic        busy,
  output logic        done,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic [3:0]  tkeep,
  output logic [3:0]  tdest,
  output logic [3:0]  tid,
  output logic [31:0] tuser,
  input  logic        tready
);

  localparam logic [31:0] CHUNK_W  = 32'(CHUNK_WORDS);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  wfrm_state_e state_q, state_d;
  logic [31:0] id_q, id_d;
  logic [31:0] len_q, len_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] chunk_q, chunk_d;
  logic [31:0] ind_q, ind_d;
  logic [31:0] gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef WFRM_PKT_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
`endif

  logic        ld_vld;
  logic [31:0] ld_dat;
  logic        ld_last;
  logic        can_ld;
  logic        gap_end;

  wfrm_axis_out_reg u_out (
    .clk_i    (axi_tclk),
    .rst_i    (axi_treset),
    .ld_vld_i (ld_vld),
    .ld_dat_i (ld_dat),
    .ld_last_i(ld_last),
    .rdy_i    (tready),
    .vld_o    (tvalid),
    .dat_o    (tdata),
    .last_o   (tlast),
    .can_ld_o (can_ld)
  );

  assign s_axis_tready = (state_q == ST_DATA) && can_ld;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tuser = len_q;
  assign tkeep = tvalid ? 4'hf : 4'h0;
  assign tdest = tvalid ? TDEST_WFRM : 4'h0;
  assign tid   = TID_WFRM;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    ind_d   = ind_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef WFRM_PKT_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    ld_vld  = 1'b0;
    ld_dat  = '0;
    ld_last = 1'b0;
    gap_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (wfrm_len != '0) begin
            id_d    = wfrm_id;
            len_d   = wfrm_len;
            rem_d   = wfrm_len;
            ind_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_CMD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (can_ld) begin
          ld_vld  = 1'b1;
          ld_dat  = CMD_WORD;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (can_ld) begin
          ld_vld  = 1'b1;
          ld_dat  = id_q;
          state_d = ST_IND;
        end
      end
      ST_IND: begin
        if (can_ld) begin
          ld_vld  = 1'b1;
          ld_dat  = ind_q;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (can_ld) begin
          ld_vld  = 1'b1;
          ld_dat  = len_q;
          // rem_q is nonzero here, so chunk never starts at 0
          chunk_d = min32(CHUNK_W, rem_q);
`ifdef WFRM_PKT_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (can_ld && s_axis_tvalid) begin
          ld_vld  = 1'b1;
          ld_dat  = s_axis_tdata;
          chunk_d = chunk_q - 32'd1;
          rem_d   = rem_q - 32'd1;
`ifdef WFRM_PKT_CHECKSUM_EN
          acc_d   = acc_q ^ s_axis_tdata;
          if (chunk_q == 32'd1) begin
            state_d = ST_TRL;
          end
`else
          ld_last = (chunk_q == 32'd1);
          if (chunk_q == 32'd1) begin
            state_d = ST_GAP;
          end
`endif
        end
      end
`ifdef WFRM_PKT_CHECKSUM_EN
      ST_TRL: begin
        if (can_ld) begin
          ld_vld  = 1'b1;
          ld_dat  = acc_q;
          ld_last = 1'b1;
          state_d = ST_GAP;
        end
      end
`endif
      ST_GAP: begin
        // tvalid high here means the tlast word is still waiting for its
        // handshake; the gap only counts cycles after it has gone out.
        if (GAP_CYCLES == 0) begin
          gap_end = can_ld;
        end else begin
          gap_end = !tvalid && (gap_q == GAP_LAST);
        end
        if (!tvalid) begin
          gap_d = gap_q + 32'd1;
        end
        if (gap_end) begin
          gap_d = '0;
          if (rem_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Load the next CMD word in the final gap cycle so the idle run
            // on the wire is exactly GAP_CYCLES long.
            ind_d   = ind_q + 32'd1;
            ld_vld  = 1'b1;
            ld_dat  = CMD_WORD;
            state_d = ST_ID;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      ind_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WFRM_PKT_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      ind_q   <= ind_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WFRM_PKT_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_waveform_packetizer.sv
module tb_waveform_packetizer;

  localparam int unsigned CHUNK = 256;
  localparam int unsigned GAP   = 24;

  logic        axi_tclk = 1'b0;
  logic        axi_treset;
  logic        start;
  logic [31:0] wfrm_id, wfrm_len;
  logic        busy, done;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic [3:0]  tkeep, tdest, tid;
  logic [31:0] tuser;
  logic        tready;

  always #5 axi_tclk = ~axi_tclk;

  waveform_packetizer #(
    .CHUNK_WORDS(CHUNK),
    .GAP_CYCLES (GAP),
    .CMD_WORD   (32'h5757_4441)
  ) dut (
    .axi_tclk     (axi_tclk),
    .axi_treset   (axi_treset),
    .start        (start),
    .wfrm_id      (wfrm_id),
    .wfrm_len     (wfrm_len),
    .busy         (busy),
    .done         (done),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .tdata        (tdata),
    .tvalid       (tvalid),
    .tlast        (tlast),
    .tkeep        (tkeep),
    .tdest        (tdest),
    .tid          (tid),
    .tuser        (tuser),
    .tready       (tready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [31:0] u;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] stim_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int popped   = 0;
  int tready_pct = 100;
  int svalid_pct = 100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: split the waveform into ceil(len/CHUNK) packets, each a
  // 4-word header followed by its slice of the samples.
  task automatic model_push(input logic [31:0] id, input logic [31:0] len);
    int unsigned npk, pos, sz;
`ifdef WFRM_PKT_CHECKSUM_EN
    logic [31:0] x;
`endif
    npk = (len + CHUNK - 1) / CHUNK;
    pos = 0;
    for (int unsigned k = 0; k < npk; k++) begin
      sz = (len - pos > CHUNK) ? CHUNK : len - pos;
      exp_q.push_back('{d: 32'h5757_4441, l: 1'b0, u: len});
      exp_q.push_back('{d: id,            l: 1'b0, u: len});
      exp_q.push_back('{d: 32'(k),        l: 1'b0, u: len});
      exp_q.push_back('{d: len,           l: 1'b0, u: len});
`ifdef WFRM_PKT_CHECKSUM_EN
      x = '0;
      for (int unsigned j = 0; j < sz; j++) begin
        x ^= stim_q[pos + j];
        exp_q.push_back('{d: stim_q[pos + j], l: 1'b0, u: len});
      end
      exp_q.push_back('{d: x, l: 1'b1, u: len});
`else
      for (int unsigned j = 0; j < sz; j++) begin
        exp_q.push_back('{d: stim_q[pos + j], l: (j == sz - 1), u: len});
      end
`endif
      pos += sz;
    end
    foreach (stim_q[i]) src_q.push_back(stim_q[i]);
  endtask

  task automatic fill(input int n);
    stim_q.delete();
    repeat (n) stim_q.push_back($urandom);
  endtask

  task automatic pulse_start(input logic [31:0] id, input logic [31:0] len);
    @(posedge axi_tclk); #1;
    start = 1'b1; wfrm_id = id; wfrm_len = len;
    @(posedge axi_tclk); #1;
    start = 1'b0; wfrm_id = $urandom; wfrm_len = $urandom;
  endtask

  task automatic run_txn(input logic [31:0] id, input logic [31:0] len,
                         input int trp, input int svp, input bit poke);
    int base, cyc, budget;
    tready_pct = trp;
    svalid_pct = svp;
    model_push(id, len);
    base = done_cnt;
    pulse_start(id, len);
    @(negedge axi_tclk);
    chk1("busy_after_start", busy, 1'b1);
    budget = 60 * int'(len) + 200 * (int'(len) / int'(CHUNK) + 1) + 500;
    cyc = 0;
    while (done_cnt == base && cyc < budget) begin
      @(posedge axi_tclk);
      cyc++;
      if (poke && cyc == 40) begin
        #1 start = 1'b1; wfrm_id = 32'hdead_beef; wfrm_len = 32'd3;
      end else if (poke && cyc == 41) begin
        #1 start = 1'b0;
      end
    end
    chk("done_seen", done_cnt - base, 32'd1);
    repeat (40) @(posedge axi_tclk);
    chk("done_count", done_cnt - base, 32'd1);
    chk1("busy_end", busy, 1'b0);
    chk("residual_exp", exp_q.size(), 32'd0);
    chk("residual_src", src_q.size(), 32'd0);
    exp_q.delete();
    src_q.delete();
  endtask

  // Downstream ready
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge axi_tclk); #1;
      tready = ($urandom_range(99) < tready_pct);
    end
  end

  // Sample source: AXIS-compliant, holds valid/data until taken
  logic src_hs;
  logic [31:0] src_dummy;
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge axi_tclk);
      src_hs = s_axis_tvalid && s_axis_tready && !axi_treset;
      @(posedge axi_tclk); #1;
      if (src_hs && src_q.size() > 0) src_dummy = src_q.pop_front();
      if (src_q.size() == 0) begin
        s_axis_tvalid = 1'b0;
      end else begin
        s_axis_tdata = src_q[0];
        if (!(s_axis_tvalid && !src_hs))
          s_axis_tvalid = ($urandom_range(99) < svalid_pct);
      end
    end
  end

  // Monitor / scoreboard
  logic        stall_v = 1'b0;
  logic [31:0] stall_d, stall_u;
  logic        stall_l;
  logic        gap_on = 1'b0;
  int          gap_run = 0;
  logic        prev_done = 1'b0;
  exp_t        e;
  initial begin
    forever begin
      @(negedge axi_tclk);
      if (axi_treset) begin
        stall_v = 1'b0;
        gap_on  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (stall_v) begin
          chk1("hold_valid", tvalid, 1'b1);
          chk("hold_data", tdata, stall_d);
          chk1("hold_last", tlast, stall_l);
          chk("hold_user", tuser, stall_u);
        end
        if (tvalid) begin
          chk("tkeep", 32'(tkeep), 32'hf);
          chk("tdest", 32'(tdest), 32'h2);
          chk("tid", 32'(tid), 32'h0);
        end
        if (s_axis_tready) begin
          chk1("src_rdy_busy", busy, 1'b1);
          chk1("src_rdy_slot", !tvalid || tready, 1'b1);
        end
        if (gap_on) begin
          if (tvalid || done) begin
            chk("gap_len", gap_run, 32'(GAP));
            gap_on = 1'b0;
          end else begin
            gap_run++;
          end
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", tdata, e.d);
            chk1("word_last", tlast, e.l);
            chk("word_user", tuser, e.u);
          end
          popped++;
          if (tlast) begin
            gap_on  = 1'b1;
            gap_run = 0;
          end
        end
        chk1("done_pulse_width", prev_done && done, 1'b0);
        prev_done = done;
        if (done) done_cnt++;
        stall_v = tvalid && !tready;
        stall_d = tdata;
        stall_l = tlast;
        stall_u = tuser;
      end
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk1({pfx, "_tvalid"}, tvalid, 1'b0);
    chk1({pfx, "_tlast"}, tlast, 1'b0);
    chk({pfx, "_tdata"}, tdata, 32'h0);
    chk({pfx, "_tkeep"}, 32'(tkeep), 32'h0);
    chk({pfx, "_tdest"}, 32'(tdest), 32'h0);
    chk({pfx, "_tuser"}, tuser, 32'h0);
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_done"}, done, 1'b0);
    chk1({pfx, "_s_tready"}, s_axis_tready, 1'b0);
  endtask

  initial begin
    int base, cyc, pbase;
    logic tv_seen;
    int unsigned rl;
    axi_treset = 1'b1;
    start = 1'b0;
    wfrm_id = '0;
    wfrm_len = '0;
    repeat (3) @(posedge axi_tclk);
    @(negedge axi_tclk);
    chk_all_zero("reset");
    @(posedge axi_tclk); #1 axi_treset = 1'b0;

    // Short single packet, then multi-packet and exact-multiple lengths
    fill(4);   run_txn(32'h11, 32'd4,   100, 100, 1'b0);
    fill(600); run_txn(32'h22, 32'd600, 100, 100, 1'b0);
    fill(512); run_txn(32'h33, 32'd512, 100, 100, 1'b0);

    // Random stalls on both sides plus a start while busy
    fill(37);  run_txn(32'h44, 32'd37,  50,  30,  1'b1);

    // Zero-length request
    tready_pct = 100;
    base = done_cnt;
    pulse_start(32'h99, 32'd0);
    @(negedge axi_tclk);
    chk1("zl_done", done, 1'b1);
    chk1("zl_busy", busy, 1'b0);
    tv_seen = 1'b0;
    repeat (10) begin
      @(negedge axi_tclk);
      if (tvalid) tv_seen = 1'b1;
    end
    chk1("zl_no_tvalid", tv_seen, 1'b0);
    chk("zl_done_count", done_cnt - base, 32'd1);

    // Reset in the middle of a payload
    fill(600);
    model_push(32'h66, 32'd600);
    tready_pct = 100;
    svalid_pct = 100;
    pbase = popped;
    pulse_start(32'h66, 32'd600);
    cyc = 0;
    while (popped - pbase < 40 && cyc < 2000) begin
      @(posedge axi_tclk);
      cyc++;
    end
    chk1("rst_reached_data", (popped - pbase) >= 40, 1'b1);
    @(posedge axi_tclk); #1 axi_treset = 1'b1;
    @(posedge axi_tclk); #1 axi_treset = 1'b0;
    @(negedge axi_tclk);
    chk_all_zero("midrst");
    exp_q.delete();
    src_q.delete();
    repeat (5) @(posedge axi_tclk);
    fill(5);   run_txn(32'h77, 32'd5, 100, 100, 1'b0);

    // Fixed payload for the checksum trailer (7 = 1^2^4)
    stim_q.delete();
    stim_q.push_back(32'd1);
    stim_q.push_back(32'd2);
    stim_q.push_back(32'd4);
    run_txn(32'h55, 32'd3, 100, 100, 1'b0);

    for (int i = 0; i < 5; i++) begin
      rl = $urandom_range(300, 1);
      fill(int'(rl));
      run_txn($urandom, rl, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
